// File: rtl/axis_pkt_fifo.sv
// Buffered AXI-Stream stage with a registered output beat. In packet mode a packet is
// held until its last beat is stored; an oversize packet that fills storage drains as a stream.
module axis_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int PKT_MODE   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [ADDR_WIDTH:0]   level,
  output logic [ADDR_WIDTH:0]   pkt_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH + 1)'(1);
  localparam bit                  PKT_EN  = (PKT_MODE != 0);

  logic [DATA_WIDTH:0]   mem_r [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_r;
  logic [ADDR_WIDTH:0]   rd_ptr_r;
  logic [ADDR_WIDTH:0]   pkt_count_r;
  logic [ADDR_WIDTH:0]   pkt_count_nxt_s;
  logic                  release_r;
  logic                  release_nxt_s;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic                  m_valid_r;
  logic                  m_last_r;

  logic [ADDR_WIDTH:0]   level_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  wr_en_s;
  logic                  out_free_s;
  logic                  pop_s;
  logic [DATA_WIDTH:0]   rd_word_s;
  logic                  rd_last_s;

  // Occupancy, handshake and pop qualification, all from registered state.
  always_comb begin
    level_s    = wr_ptr_r - rd_ptr_r;
    full_s     = (level_s == DEPTH_L);
    empty_s    = (level_s == '0);
    wr_en_s    = s_valid && reset && !full_s;
    out_free_s = !m_valid_r || m_ready;
    rd_word_s  = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
    rd_last_s  = rd_word_s[DATA_WIDTH];
    pop_s      = out_free_s && !empty_s &&
                 (!PKT_EN || (pkt_count_r != '0) || release_r);
  end

  // Complete-packet counter and oversize-release flag next state.
  always_comb begin
    pkt_count_nxt_s = pkt_count_r;
    release_nxt_s   = release_r;
    case ({wr_en_s && s_last, pop_s && rd_last_s})
      2'b10:   pkt_count_nxt_s = pkt_count_r + ONE_L;
      2'b01:   pkt_count_nxt_s = pkt_count_r - ONE_L;
      default: pkt_count_nxt_s = pkt_count_r;
    endcase
    // Full storage with no complete packet can only be an oversize packet: let it stream out.
    if (pop_s && rd_last_s) begin
      release_nxt_s = 1'b0;
    end else if (PKT_EN && full_s && (pkt_count_r == '0)) begin
      release_nxt_s = 1'b1;
    end else begin
      release_nxt_s = release_r;
    end
  end

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= {s_last, s_data};
    end
  end

  // Pointers, packet state and the output beat register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      pkt_count_r <= '0;
      release_r   <= 1'b0;
      m_data_r    <= '0;
      m_valid_r   <= 1'b0;
      m_last_r    <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_L;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_L;
      end
      pkt_count_r <= pkt_count_nxt_s;
      release_r   <= release_nxt_s;
      if (pop_s) begin
        m_data_r  <= rd_word_s[DATA_WIDTH-1:0];
        m_last_r  <= rd_last_s;
        m_valid_r <= 1'b1;
      end else if (out_free_s) begin
        m_valid_r <= 1'b0;
      end
    end
  end

  assign s_ready   = reset && !full_s;
  assign m_data    = m_data_r;
  assign m_valid   = m_valid_r;
  assign m_last    = m_last_r;
  assign level     = level_s;
  assign pkt_count = pkt_count_r;

endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Buffered AXI-Stream stage that sits directly downstream of the 2:1 AXI-Stream mux. It consumes the mux's `m_data`/`m_valid`/`m_last` stream and absorbs `m_ready` stalls from the sink. It re-emits the stream in order through a registered output port. In packet mode it forwards a packet only after that packet's `last` beat is stored, so packets from the two mux inputs leave as unbroken bursts.

## Interface
- `DATA_WIDTH`, 8, width of the data beat.
- `DEPTH`, 16, number of storage entries; must be a power of 2 and ≥ 4.
- `ADDR_WIDTH`, log2(DEPTH), derived; not to be overridden.
- `PKT_MODE`, 1. 1 = store-and-forward per packet; 0 = plain stream FIFO.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_data`  in  DATA_WIDTH  upstream beat (from mux `m_data`).
- `s_valid`  in  1  upstream valid.
- `s_ready`  out  1  upstream ready.
- `s_last`  in  1  final beat of the packet.
- `m_data`  out  DATA_WIDTH  downstream beat, registered.
- `m_valid`  out  1  downstream valid, registered.
- `m_ready`  in  1  downstream ready.
- `m_last`  out  1  downstream last, registered.
- `level`  out  ADDR_WIDTH+1  storage occupancy (excludes output register).
- `pkt_count`  out  ADDR_WIDTH+1  complete packets (last beat present) in storage.

## Operation
- **Storage**
  - DEPTH × {last, data} array.
  - `wr_ptr`/`rd_ptr` are ADDR_WIDTH+1 bits and wrap naturally.
  - `level` = wr_ptr − rd_ptr; full when `level` == DEPTH; empty when 0.
- **Write side**
  - `s_ready` = `reset` AND NOT full (combinational from registered state).
  - A beat is written on an edge with `s_valid` && `s_ready`.
- **Output register**
  - Holds one beat.
  - It is "free" when `m_valid`=0, or when `m_valid` && `m_ready` on this edge.
  - A pop loads storage[rd_ptr] into `m_data`/`m_last` and sets `m_valid`=1.
  - If the register is free and no pop occurs, `m_valid` clears.
- **Pop condition:** output register free AND storage not empty AND (`PKT_MODE`==0 OR `pkt_count`>0 OR `release`).
- **`pkt_count` update**
  - +1 on writing a beat with last=1.
  - −1 on popping a beat with last=1.
  - Both on the same edge: unchanged.
- **`release` flag** (PKT_MODE=1 only)
  - Set when full and `pkt_count`==0, so an oversize packet cannot deadlock.
  - Cleared on the edge that pops a beat with last=1.
  - While set, beats drain as in stream mode.
- **Ordering:** beats leave in arrival order. In packet mode, once a packet's last is stored, all its beats are eligible.
- **`s_last` with `s_valid`=0** is ignored.
- **Reset** (`reset`=0, asynchronous):
  - Pointers, `pkt_count` and `release` cleared.
  - `m_valid`=0, `m_last`=0, `m_data`=0.
  - `level`=0, `pkt_count`=0, `s_ready`=0.
  - Storage contents are not cleared.
  - Reset mid-packet discards all buffered beats; the partial packet is lost.

## Timing
- **Stream mode latency:** a beat written at edge E is visible on `m_valid` after edge E+1, provided the output register is free at E+1.
- **Packet mode latency:** last beat written at edge E → `pkt_count` increments after E → first beat of that packet is on `m_valid` after E+1.
- **Throughput:** one beat per cycle on each side with `m_ready` held 1 and `s_valid` held 1; no bubbles.
- **Capacity:** with `m_ready`=0 and stream mode, DEPTH+1 beats are accepted (DEPTH in storage, 1 in the output register).
- **Full/empty:**
  - Simultaneous write and pop on a full FIFO is impossible, because `s_ready`=0.
  - On an empty FIFO, a write and an output-register drain on the same edge leave `m_valid`=0 for one cycle. There is no bypass path.
- **Output stability:** `m_data`/`m_last` hold stable while `m_valid`=1 and `m_ready`=0.
- **`s_ready` after reset:** rises combinationally when `reset` deasserts, because `level`=0.

## Test plan
- **Reset mid-stream:** PKT_MODE=0, 6 beats written, drive `reset`=0 for 2 cycles → `m_valid`=0, `level`=0, `pkt_count`=0, `s_ready`=0 during reset, `s_ready`=1 immediately after release; no old beat is ever output.
- **Stream pass-through:** PKT_MODE=0, beats 0x01..0x14, last on 0x14, `m_ready`=1 → identical sequence, first `m_valid` one cycle after first write, 20 consecutive beats, `m_last` only with 0x14.
- **Packet hold:** PKT_MODE=1, beats 0xA0..0xA4 (last on A4) written with gaps, `m_ready`=1 → `m_valid`=0 until edge after A4 write; then A0..A4 on 5 consecutive cycles; `pkt_count` 1→0.
- **Backpressure/full:** PKT_MODE=0, DEPTH=16, `m_ready`=0, 20 beats offered → exactly 17 accepted, `level`=16, `s_ready`=0. Then `m_ready`=1 → `s_ready` reasserts after first pop; all 20 beats delivered in order; `m_data` stable while stalled.
- **Oversize packet release:** PKT_MODE=1, DEPTH=16, 24-beat packet (last on beat 24), `m_ready`=1 → full with `pkt_count`=0 sets `release`; beats drain; all 24 delivered in order; `release` clears after beat 24 pops.
- **Simultaneous last in/out:** PKT_MODE=1, two back-to-back 3-beat packets, with packet 2's last written on the same edge packet 1's last pops → `pkt_count` stays 1; packet 2 follows with no gap.
